// File: rtl/multiport_ckpt_fifo.sv
// multiport_ckpt_fifo: multi-lane circular FIFO with a read-pointer checkpoint for speculative pops
module multiport_ckpt_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_WR = 2,
    parameter int NUM_RD = 2,
    parameter int INIT_COUNT = 0,
    parameter int INIT_START = 0,
    localparam int CW = $clog2(NUM_RD + 1)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_WR-1:0]                wr_en,
    input  logic [NUM_WR-1:0][DATA_WIDTH-1:0] wr_data,
    output logic                             wr_accept,
    input  logic [CW-1:0]                    rd_cnt,
    output logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]                rd_valid,
    output logic                             rd_err,
    input  logic                             ckpt_save,
    input  logic                             ckpt_restore,
    input  logic                             ckpt_release,
    output logic                             ckpt_valid,
    output logic [ADDR_WIDTH:0]              count,
    output logic [ADDR_WIDTH:0]              free_slots,
    output logic                             full,
    output logic                             empty
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int PW = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr, ckpt_ptr, rd_next, nw, pop_cnt;
    logic [NUM_WR-1:0][ADDR_WIDTH-1:0] wr_idx;
    logic restore;

    assign count = wr_ptr - rd_ptr;
    // Slots popped since the checkpoint stay reserved so a restore can replay them
    assign free_slots = PW'(DEPTH) - (wr_ptr - (ckpt_valid ? ckpt_ptr : rd_ptr));
    assign full = free_slots == '0;
    assign empty = count == '0;
    assign wr_accept = nw <= free_slots;
    assign restore = ckpt_restore && ckpt_valid;
    assign pop_cnt = PW'(rd_cnt);
    assign rd_err = !restore && pop_cnt > count;
    assign rd_next = restore ? ckpt_ptr : rd_err ? rd_ptr : rd_ptr + pop_cnt;

    // Running popcount of write enables gives each set lane its compacted slot offset
    always_comb begin
        nw = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            wr_idx[i] = wr_ptr[ADDR_WIDTH-1:0] + nw[ADDR_WIDTH-1:0];
            nw = nw + PW'(wr_en[i]);
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        assign rd_data[i] = mem[rd_ptr[ADDR_WIDTH-1:0] + ADDR_WIDTH'(i)];
        assign rd_valid[i] = PW'(i) < count;
    end

    // Storage: preloaded on reset, accepted lanes written at their compacted slots
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < DEPTH; j++)
                mem[j] <= j < INIT_COUNT ? DATA_WIDTH'(INIT_START + j) : '0;
        end else if (wr_accept) begin
            for (int j = 0; j < NUM_WR; j++)
                if (wr_en[j]) mem[wr_idx[j]] <= wr_data[j];
        end
    end

    // Pointer and checkpoint update; restore outranks save, save outranks release
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= PW'(INIT_COUNT);
            ckpt_ptr <= '0;
            ckpt_valid <= 1'b0;
        end else begin
            if (wr_accept) wr_ptr <= wr_ptr + nw;
            rd_ptr <= rd_next;
            if (restore) begin
                ckpt_valid <= 1'b0;
            end else if (ckpt_save) begin
                ckpt_ptr <= rd_next;
                ckpt_valid <= 1'b1;
            end else if (ckpt_release) begin
                ckpt_valid <= 1'b0;
            end
        end
    end
endmodule
